// File: rtl/vga_fb_160x120.sv
// vga_fb_160x120: 160x120 RGB332 framebuffer with a 4x-scaled combinational display read,
// a CPU write/readback port and a hardware full-buffer clear engine.
module vga_fb_160x120 #(
    parameter int FB_W     = 160,
    parameter int FB_H     = 120,
    parameter int SCALE_SH = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [9:0] ROW,
    input  logic [9:0] COLUMN,
    output logic [3:0] RED,
    output logic [3:0] GREEN,
    output logic [3:0] BLUE,
    input  logic [7:0] WR_X,
    input  logic [6:0] WR_Y,
    input  logic [7:0] WR_DATA,
    input  logic       WR_VALID,
    output logic       WR_READY,
    output logic [7:0] RD_DATA,
    input  logic       CLR_START,
    input  logic [7:0] CLR_COLOR,
    output logic       BUSY,
    output logic       CLR_DONE
);
    localparam int DEPTH = FB_W * FB_H;
    localparam logic [14:0] LAST = 15'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t      state, state_nx;
    logic [14:0] cnt, cnt_nx;
    logic [7:0]  clr_col, clr_col_nx;
    logic        done_nx;
    logic [7:0]  mem [DEPTH];
    logic [9:0]  px, py;
    logic        disp_ok, wr_ok;
    logic [14:0] disp_addr, wr_addr;
    logic [7:0]  pix;

    // y*160 folded into two shifts and adds
    function automatic logic [14:0] addr(input logic [9:0] x, input logic [9:0] y);
        return ({5'd0, y} << 7) + ({5'd0, y} << 5) + {5'd0, x};
    endfunction

    assign px        = COLUMN >> SCALE_SH;
    assign py        = ROW >> SCALE_SH;
    assign disp_ok   = (COLUMN < 10'(FB_W << SCALE_SH)) && (ROW < 10'(FB_H << SCALE_SH));
    assign disp_addr = addr(px, py);
    assign pix       = disp_ok ? mem[disp_addr] : 8'd0;
    assign RED       = {pix[7:5], pix[7]};
    assign GREEN     = {pix[4:2], pix[4]};
    assign BLUE      = {pix[1:0], pix[1:0]};

    assign wr_ok    = (WR_X < 8'(FB_W)) && (WR_Y < 7'(FB_H));
    assign wr_addr  = addr({2'd0, WR_X}, {3'd0, WR_Y});
    assign WR_READY = (state == IDLE);
    assign BUSY     = (state == CLEAR);

    // the clear engine owns the write port; CPU writes only land while idle
    always_ff @(posedge CLK) begin
        if (state == CLEAR) mem[cnt] <= clr_col;
        else if (WR_VALID && wr_ok) mem[wr_addr] <= WR_DATA;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            cnt      <= '0;
            clr_col  <= '0;
            RD_DATA  <= '0;
            CLR_DONE <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            clr_col  <= clr_col_nx;
            RD_DATA  <= wr_ok ? mem[wr_addr] : 8'd0;
            CLR_DONE <= done_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        clr_col_nx = clr_col;
        done_nx    = (state == CLEAR) && (cnt == LAST);
        if (state == IDLE && CLR_START) begin
            state_nx   = CLEAR;
            cnt_nx     = '0;
            clr_col_nx = CLR_COLOR;
        end else if (state == CLEAR) begin
            state_nx = done_nx ? IDLE : CLEAR;
            cnt_nx   = done_nx ? 15'd0 : cnt + 15'd1;
        end
    end
endmodule
